skullfet_wb_tester: RTL and testbench

Wishbone responder on the Caravel management bus that runs an on-chip functional test of a SkullFET inverter cell. Firmware programs a toggle period and count. The block drives the cell input, samples the cell output through a synchronizer, and counts mismatches against the expected inverted value. It raises an interrupt when the run ends. It sits in the user project wrapper between the `wbs_*` ports and the SkullFET cell pins.

---
 rtl/skullfet_pkg.sv | 45 ++++
 rtl/skullfet_wb_regs.sv | 121 ++++++++++++
 rtl/skullfet_wb_tester.sv | 165 ++++++++++++++++
 tb/tb_skullfet_wb_tester.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skullfet_pkg.sv
// Shared constants, register map and sequencer state encoding for the
// SkullFET inverter functional tester.
package skullfet_pkg;

   localparam int unsigned PERIOD_W = 16;
   localparam int unsigned MIS_W    = 16;
   localparam int unsigned PERIOD_MIN = 3;

   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_PERIOD = 8'h04;
   localparam logic [7:0] OFF_COUNT  = 8'h08;
   localparam logic [7:0] OFF_STATUS = 8'h0C;
   localparam logic [7:0] OFF_OBS    = 8'h10;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_START  = 1;
   localparam int unsigned CTRL_IRQ_EN = 2;
   localparam int unsigned CTRL_MANUAL = 3;

   localparam int unsigned STAT_DONE    = 0;
   localparam int unsigned STAT_BUSY    = 1;
   localparam int unsigned STAT_MIS_LSB = 16;

   localparam int unsigned OBS_RESP = 0;
   localparam int unsigned OBS_STIM = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Merge write data into an existing word honouring byte-lane selects.
   function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/skullfet_wb_regs.sv
// Wishbone slave for the tester: window decode, single-cycle ack,
// control/config register storage and readback mux.
module skullfet_wb_regs
   import skullfet_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_cyc,
   input  logic                i_stb,
   input  logic                i_we,
   input  logic [3:0]          i_sel,
   input  logic [31:0]         i_adr,
   input  logic [31:0]         i_dat,
   output logic                o_ack,
   output logic [31:0]         o_dat,
   output logic                o_en,
   output logic                o_irq_en_nxt_c,
   output logic                o_manual,
   output logic                o_start,
   output logic [PERIOD_W-1:0] o_period,
   output logic [CNT_W-1:0]    o_count,
   output logic                o_done_w1c_c,
   input  logic                i_done,
   input  logic                i_busy,
   input  logic [MIS_W-1:0]    i_mismatch,
   input  logic                i_obs_resp,
   input  logic                i_obs_stim
);

   logic                r_ack;
   logic [31:0]         r_dat;
   logic                r_en;
   logic                r_irq_en;
   logic                r_manual;
   logic                r_start;
   logic [PERIOD_W-1:0] r_period;
   logic [CNT_W-1:0]    r_count;

   logic        w_hit;
   logic        w_acc;
   logic        w_wr;
   logic [7:0]  w_off;
   logic [3:0]  w_ctrl_m;
   logic [31:0] w_rdata;

   assign w_off = i_adr[7:0];
   assign w_hit = (i_adr[31:8] == BASE_ADDR[31:8]);
   assign w_acc = i_cyc & i_stb & ~r_ack & w_hit;
   assign w_wr  = w_acc & i_we;

   assign w_ctrl_m = 4'(apply_sel({28'd0, r_manual, r_irq_en, 1'b0, r_en}, i_dat, i_sel));

   // Next IRQ_EN lets the interrupt track a CTRL write on the same edge.
   assign o_irq_en_nxt_c = (w_wr && w_off == OFF_CTRL) ? w_ctrl_m[CTRL_IRQ_EN] : r_irq_en;
   assign o_done_w1c_c   = w_wr && (w_off == OFF_STATUS) && i_sel[0] && i_dat[0];

   always_comb begin
      w_rdata = '0;
      case (w_off)
         OFF_CTRL: begin
            w_rdata[CTRL_EN]     = r_en;
            w_rdata[CTRL_IRQ_EN] = r_irq_en;
            w_rdata[CTRL_MANUAL] = r_manual;
         end
         OFF_PERIOD: w_rdata = 32'(r_period);
         OFF_COUNT:  w_rdata = 32'(r_count);
         OFF_STATUS: begin
            w_rdata[STAT_DONE]                = i_done;
            w_rdata[STAT_BUSY]                = i_busy;
            w_rdata[STAT_MIS_LSB +: MIS_W]    = i_mismatch;
         end
         OFF_OBS: begin
            w_rdata[OBS_RESP] = i_obs_resp;
            w_rdata[OBS_STIM] = i_obs_stim;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ack    <= 1'b0;
         r_dat    <= '0;
         r_en     <= 1'b0;
         r_irq_en <= 1'b0;
         r_manual <= 1'b0;
         r_start  <= 1'b0;
         r_period <= PERIOD_W'(PERIOD_MIN);
         r_count  <= '0;
      end else begin
         r_ack   <= w_acc;
         r_dat   <= (w_acc && !i_we) ? w_rdata : '0;
         r_start <= 1'b0;
         if (w_wr) begin
            case (w_off)
               OFF_CTRL: begin
                  r_en     <= w_ctrl_m[CTRL_EN];
                  r_irq_en <= w_ctrl_m[CTRL_IRQ_EN];
                  r_manual <= w_ctrl_m[CTRL_MANUAL];
                  r_start  <= w_ctrl_m[CTRL_START];
               end
               OFF_PERIOD: r_period <= PERIOD_W'(apply_sel(32'(r_period), i_dat, i_sel));
               OFF_COUNT:  r_count  <= CNT_W'(apply_sel(32'(r_count), i_dat, i_sel));
               default: ;
            endcase
         end
      end
   end

   assign o_ack    = r_ack;
   assign o_dat    = r_dat;
   assign o_en     = r_en;
   assign o_manual = r_manual;
   assign o_start  = r_start;
   assign o_period = r_period;
   assign o_count  = r_count;

endmodule

// File: rtl/skullfet_wb_tester.sv
// SkullFET inverter tester: drives the cell input, synchronizes the cell
// output and counts responses that are not the inverse of the stimulus.
module skullfet_wb_tester
   import skullfet_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned CNT_W     = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        stim_o,
   output logic        stim_oeb_o,
   input  logic        resp_i,
   output logic        irq_o
);

   state_e              r_state;
   logic [1:0]          r_sync;
   logic                r_stim;
   logic                r_oeb;
   logic                r_irq;
   logic [CNT_W-1:0]    r_rem;
   logic [PERIOD_W-1:0] r_hold;
   logic [CNT_W-1:0]    r_mis;
   logic                r_done;

   state_e              w_state_nxt;
   logic                w_stim_nxt;
   logic [CNT_W-1:0]    w_rem_nxt;
   logic [PERIOD_W-1:0] w_hold_nxt;
   logic [CNT_W-1:0]    w_mis_nxt;
   logic                w_done_nxt;

   logic                w_en;
   logic                w_irq_en_nxt;
   logic                w_manual;
   logic                w_start;
   logic [PERIOD_W-1:0] w_period;
   logic [PERIOD_W-1:0] w_period_eff;
   logic [CNT_W-1:0]    w_count;
   logic                w_done_w1c;
   logic                w_busy;
   logic                w_sync_resp;

   skullfet_wb_regs #(
      .BASE_ADDR (BASE_ADDR),
      .CNT_W     (CNT_W)
   ) u_regs (
      .i_clk          (wb_clk_i),
      .i_rst          (wb_rst_i),
      .i_cyc          (wbs_cyc_i),
      .i_stb          (wbs_stb_i),
      .i_we           (wbs_we_i),
      .i_sel          (wbs_sel_i),
      .i_adr          (wbs_adr_i),
      .i_dat          (wbs_dat_i),
      .o_ack          (wbs_ack_o),
      .o_dat          (wbs_dat_o),
      .o_en           (w_en),
      .o_irq_en_nxt_c (w_irq_en_nxt),
      .o_manual       (w_manual),
      .o_start        (w_start),
      .o_period       (w_period),
      .o_count        (w_count),
      .o_done_w1c_c   (w_done_w1c),
      .i_done         (r_done),
      .i_busy         (w_busy),
      .i_mismatch     (MIS_W'(r_mis)),
      .i_obs_resp     (w_sync_resp),
      .i_obs_stim     (r_stim)
   );

   assign w_sync_resp  = r_sync[1];
   assign w_busy       = (r_state == ST_HOLD) || (r_state == ST_CHECK);
   assign w_period_eff = (w_period < PERIOD_W'(PERIOD_MIN)) ? PERIOD_W'(PERIOD_MIN) : w_period;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_sync  <= '0;
         r_stim  <= 1'b0;
         r_oeb   <= 1'b1;
         r_irq   <= 1'b0;
         r_rem   <= '0;
         r_hold  <= '0;
         r_mis   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sync  <= {r_sync[0], resp_i};
         r_stim  <= w_stim_nxt;
         r_oeb   <= ~w_en;
         r_irq   <= w_done_nxt & w_irq_en_nxt;
         r_rem   <= w_rem_nxt;
         r_hold  <= w_hold_nxt;
         r_mis   <= w_mis_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Sequencer; DONE is flagged on entry so a same-cycle W1C loses.
   always_comb begin
      w_state_nxt = r_state;
      w_stim_nxt  = r_stim;
      w_rem_nxt   = r_rem;
      w_hold_nxt  = r_hold;
      w_mis_nxt   = r_mis;
      w_done_nxt  = r_done;

      if (w_done_w1c) w_done_nxt = 1'b0;
      if (r_state == ST_IDLE) w_stim_nxt = w_manual;

      if (!w_en) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (r_state == ST_DONE) w_state_nxt = ST_IDLE;
               if (w_start) begin
                  w_mis_nxt  = '0;
                  w_done_nxt = 1'b0;
                  if (w_count == '0) begin
                     w_state_nxt = ST_DONE;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = ST_HOLD;
                     w_rem_nxt   = w_count;
                     w_hold_nxt  = w_period_eff - PERIOD_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (r_hold == '0) w_state_nxt = ST_CHECK;
               else              w_hold_nxt  = r_hold - PERIOD_W'(1);
            end
            ST_CHECK: begin
               if (w_sync_resp == r_stim && r_mis != '1) w_mis_nxt = r_mis + CNT_W'(1);
               w_stim_nxt = ~r_stim;
               w_rem_nxt  = r_rem - CNT_W'(1);
               if (r_rem == CNT_W'(1)) begin
                  w_state_nxt = ST_DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_HOLD;
                  w_hold_nxt  = w_period_eff - PERIOD_W'(1);
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign stim_o     = r_stim;
   assign stim_oeb_o = r_oeb;
   assign irq_o      = r_irq;

endmodule

// File: tb/tb_skullfet_wb_tester.sv
// Scoreboarded bench for skullfet_wb_tester: bus reads queue expected data,
// a monitor compares on ack; a cell model drives resp_i from stim_o.
module tb_skullfet_wb_tester;

   localparam logic [31:0] BASE     = 32'h3000_0000;
   localparam logic [7:0]  A_CTRL   = 8'h00;
   localparam logic [7:0]  A_PERIOD = 8'h04;
   localparam logic [7:0]  A_COUNT  = 8'h08;
   localparam logic [7:0]  A_STATUS = 8'h0C;
   localparam logic [7:0]  A_OBS    = 8'h10;

   logic        clk, rst, cyc, stb, we, ack, stim, oeb, resp, irq;
   logic [3:0]  sel;
   logic [31:0] adr, dat_w, dat_r;

   typedef struct {
      bit          chk;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks, n_pass;
   int   ack_total, ack_viol, dat_viol;
   int   toggles, spc_bad, spc_exp, spc_n, cyc_cnt, last_t;
   bit   spc_on;
   int   resp_mode;
   logic prev_ack, prev_stim;

   skullfet_wb_tester dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wbs_cyc_i  (cyc),
      .wbs_stb_i  (stb),
      .wbs_we_i   (we),
      .wbs_sel_i  (sel),
      .wbs_adr_i  (adr),
      .wbs_dat_i  (dat_w),
      .wbs_ack_o  (ack),
      .wbs_dat_o  (dat_r),
      .stim_o     (stim),
      .stim_oeb_o (oeb),
      .resp_i     (resp),
      .irq_o      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Cell model: 0 good inverter, 1 stuck-0, 2 stuck-1, 3 acts as buffer.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (resp_mode)
            0:       resp = ~stim;
            1:       resp = 1'b0;
            2:       resp = 1'b1;
            default: resp = stim;
         endcase
      end
   end

   // Response monitor: pops one scoreboard entry per ack.
   always @(negedge clk) begin
      exp_t e;
      if (ack) begin
         ack_total++;
         if (prev_ack) ack_viol++;
         if (sb_q.size() == 0) begin
            check("unexpected_ack", 32'(ack), 32'd0);
         end else begin
            e = sb_q.pop_front();
            if (e.chk) check(e.name, dat_r, e.exp);
         end
      end else if (dat_r !== 32'd0) begin
         dat_viol++;
      end
      prev_ack = ack;
   end

   // Stimulus toggle monitor: counts edges and checks their spacing.
   always @(negedge clk) begin
      if (stim !== prev_stim) begin
         toggles++;
         if (spc_on && toggles <= spc_n && last_t >= 0 && (cyc_cnt - last_t) != spc_exp) spc_bad++;
         last_t = cyc_cnt;
      end
      prev_stim = stim;
   end

   task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit chk, input logic [31:0] exp, input string name, input bit hold);
      exp_t e;
      bit   got;
      e.chk = chk;
      e.exp = exp;
      e.name = name;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (ack) begin
            got = 1'b1;
            break;
         end
      end
      if (hold) begin
         @(posedge clk);
         #1;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (!got) begin
         check({name, "_ack"}, 32'(got), 32'd1);
         void'(sb_q.pop_back());
      end
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d);
      bus(1'b1, BASE + 32'(off), d, 4'hF, 1'b0, 32'd0, "wr", 1'b0);
   endtask

   task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
      bus(1'b0, BASE + 32'(off), 32'd0, 4'hF, 1'b1, exp, name, 1'b0);
   endtask

   // Reference: k-th check drives STIM_MANUAL ^ k and expects the inverse.
   function automatic int model_mis(input int count, input bit manual, input int mode);
      int m;
      m = 0;
      for (int k = 0; k < count; k++) begin
         bit s, want, got;
         s    = manual ^ k[0];
         want = ~s;
         case (mode)
            0:       got = want;
            1:       got = 1'b0;
            2:       got = 1'b1;
            default: got = s;
         endcase
         if (got != want) m++;
      end
      return m;
   endfunction

   task automatic run_test(input int period, input int count, input bit manual,
                           input bit irq_en, input int mode, input string tag);
      int          pe, mis;
      logic [31:0] ctrl;
      pe   = (period < 3) ? 3 : period;
      mis  = model_mis(count, manual, mode);
      resp_mode = mode;
      ctrl = 32'h1 | (irq_en ? 32'h4 : 32'h0) | (manual ? 32'h8 : 32'h0);
      wr(A_PERIOD, 32'(period));
      wr(A_COUNT, 32'(count));
      wr(A_CTRL, ctrl);
      repeat (6) @(posedge clk);
      #1;
      check({tag, "_oeb_en"}, 32'(oeb), 32'd0);
      check({tag, "_idle_stim"}, 32'(stim), 32'(manual));
      toggles = 0; last_t = -1; spc_exp = pe + 1; spc_n = count; spc_on = 1'b1;
      wr(A_CTRL, ctrl | 32'h2);
      repeat (count * (pe + 1) + 8) @(posedge clk);
      #1;
      spc_on = 1'b0;
      check({tag, "_toggles"}, 32'(toggles), 32'(count + (count % 2)));
      check({tag, "_end_stim"}, 32'(stim), 32'(manual));
      check({tag, "_irq"}, 32'(irq), 32'(irq_en));
      rd(A_STATUS, {16'(mis), 16'h0001}, {tag, "_status"});
      rd(A_PERIOD, 32'(period), {tag, "_period_rb"});
      wr(A_STATUS, 32'h1);
      check({tag, "_irq_w1c"}, 32'(irq), 32'd0);
      rd(A_STATUS, {16'(mis), 16'h0000}, {tag, "_status_w1c"});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      bit got;
      n_checks = 0; n_pass = 0; ack_total = 0; ack_viol = 0; dat_viol = 0;
      toggles = 0; spc_bad = 0; spc_exp = 0; spc_n = 0; cyc_cnt = 0; last_t = -1; spc_on = 1'b0;
      prev_ack = 1'b0; prev_stim = 1'b0;
      resp_mode = 1; resp = 1'b0;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_dat", dat_r, 32'd0);
      check("rst_stim", 32'(stim), 32'd0);
      check("rst_oeb", 32'(oeb), 32'd1);
      check("rst_irq", 32'(irq), 32'd0);
      rst = 1'b0;

      rd(A_CTRL, 32'h0, "rst_ctrl");
      rd(A_PERIOD, 32'h3, "rst_period");
      rd(A_COUNT, 32'h0, "rst_count");
      rd(A_STATUS, 32'h0, "rst_status");
      rd(A_OBS, 32'h0, "rst_obs");
      rd(8'h14, 32'h0, "unmapped_14");
      rd(8'hFC, 32'h0, "unmapped_fc");

      // Outside the window: must never be acknowledged.
      @(posedge clk);
      #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100; sel = 4'hF;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (ack) got = 1'b1;
      end
      cyc = 1'b0; stb = 1'b0;
      check("oow_no_ack", 32'(got), 32'd0);

      a0 = ack_total;
      bus(1'b1, BASE + 32'(A_PERIOD), 32'h1234, 4'b0001, 1'b0, 32'd0, "bytewr", 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("bytewr_ack_count", 32'(ack_total - a0), 32'd1);
      rd(A_PERIOD, 32'h34, "bytewr_period");

      run_test(5, 4, 1'b0, 1'b1, 0, "good");
      run_test(3, 6, 1'b0, 1'b0, 1, "stuck0");

      // Abort by clearing EN after two checks.
      resp_mode = 1;
      wr(A_PERIOD, 32'd6);
      wr(A_COUNT, 32'd10);
      wr(A_CTRL, 32'h1);
      repeat (6) @(posedge clk);
      toggles = 0;
      wr(A_CTRL, 32'h3);
      for (int i = 0; i < 200 && toggles < 2; i++) @(posedge clk);
      check("abort_two_checks", 32'(toggles), 32'd2);
      wr(A_CTRL, 32'h8);
      repeat (4) @(posedge clk);
      #1;
      check("abort_stim_manual", 32'(stim), 32'd1);
      check("abort_oeb", 32'(oeb), 32'd1);
      rd(A_STATUS, {16'd1, 16'h0000}, "abort_status");
      rd(A_OBS, 32'h2, "abort_obs");
      wr(A_STATUS, 32'h1);
      wr(A_COUNT, 32'd0);
      wr(A_CTRL, 32'hB);
      repeat (3) @(posedge clk);
      rd(A_STATUS, 32'h0000_0001, "zero_count_status");
      check("zero_count_irq", 32'(irq), 32'd0);

      // Reset while holding.
      resp_mode = 0;
      wr(A_PERIOD, 32'd8);
      wr(A_COUNT, 32'd5);
      wr(A_CTRL, 32'hD);
      repeat (6) @(posedge clk);
      wr(A_CTRL, 32'hF);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_stim", 32'(stim), 32'd0);
      check("midrst_oeb", 32'(oeb), 32'd1);
      check("midrst_irq", 32'(irq), 32'd0);
      check("midrst_ack", 32'(ack), 32'd0);
      check("midrst_dat", dat_r, 32'd0);
      rst = 1'b0;
      rd(A_CTRL, 32'h0, "midrst_ctrl");
      rd(A_PERIOD, 32'h3, "midrst_period");
      rd(A_COUNT, 32'h0, "midrst_count");
      rd(A_STATUS, 32'h0, "midrst_status");
      run_test(8, 5, 1'b1, 1'b1, 0, "post_rst");

      for (int r = 0; r < 6; r++) begin
         run_test(int'($urandom_range(0, 7)), int'($urandom_range(1, 9)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)), $sformatf("rnd%0d", r));
      end

      repeat (4) @(posedge clk);
      check("ack_single_cycle", 32'(ack_viol), 32'd0);
      check("dat_zero_without_ack", 32'(dat_viol), 32'd0);
      check("check_spacing", 32'(spc_bad), 32'd0);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
